// File: rtl/mem_access_stage_if.sv
// Data-memory request/grant/response bus between mem_access_stage (master) and
// the data memory (slave).
interface mem_access_stage_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            o_dmem_req;
  logic            i_dmem_gnt;
  logic [XLEN-1:0] o_dmem_addr;
  logic            o_dmem_we;
  logic [NB-1:0]   o_dmem_be;
  logic [XLEN-1:0] o_dmem_wdata;
  logic            i_dmem_rvalid;
  logic [XLEN-1:0] i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_be, o_dmem_wdata,
    input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_addr, o_dmem_we, o_dmem_be, o_dmem_wdata,
    output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: dmem handshake, byte-lane alignment, load extension.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module mem_access_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_writeback,
  input  logic [RW-1:0]      i_rd,
  input  logic               i_mem_r,
  input  logic               i_mem_w,
  input  logic               i_mem_rdu,
  input  logic [1:0]         i_size,
  input  logic [XLEN-1:0]    i_alu_result,
  input  logic [XLEN-1:0]    i_wdata,
  mem_access_stage_if.master dmem,
  output logic               o_valid,
  output logic               o_writeback,
  output logic [RW-1:0]      o_rd,
  output logic [XLEN-1:0]    o_data,
  output logic               o_misalign
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            rdu_q, rdu_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            wb_q, wb_d;
  logic            valid_q, valid_d;
  logic            wbo_q, wbo_d;
  logic [RW-1:0]   rdo_q, rdo_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            mis_q, mis_d;
  logic            req_q, req_d;
  logic            dwe_q, dwe_d;
  logic [NB-1:0]   be_q, be_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] dwdata_q, dwdata_d;

  logic [OW-1:0]   off_in;
  logic [15:0]     mask16;
  logic [NB-1:0]   be_in;
  logic [XLEN-1:0] wdata_in;
  logic [XLEN-1:0] addr_in;
  logic            trap_in;
  logic [XLEN-1:0] rot;
  logic [6:0]      sh;
  logic [XLEN-1:0] shl;
  logic signed [XLEN-1:0] sext;
  logic [XLEN-1:0] ext;

  always_comb begin
    off_in = i_alu_result[OW-1:0];
    case (i_size)
      2'd0:    mask16 = 16'h0001;
      2'd1:    mask16 = 16'h0003;
      2'd2:    mask16 = 16'h000F;
      default: mask16 = 16'h00FF;
    endcase
    // Lanes shifted past NB-1 fall off the top of the enable vector.
    be_in    = NB'(mask16 << off_in);
    wdata_in = i_wdata << {off_in, 3'b000};
    addr_in  = {i_alu_result[XLEN-1:OW], {OW{1'b0}}};
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_in = |(off_in & OW'((32'd1 << i_size) - 32'd1));
`else
  assign trap_in = 1'b0;
`endif

  // Rotate read data so the addressed lane lands at byte 0, wrapping in the word.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [OW-1:0] src;
      assign src = OW'(gi) + off_q;
      assign rot[8*gi +: 8] = dmem.i_dmem_rdata[{src, 3'b000} +: 8];
    end
  endgenerate

  always_comb begin
    case (size_q)
      2'd0:    sh = 7'(XLEN - 8);
      2'd1:    sh = 7'(XLEN - 16);
      2'd2:    sh = 7'(XLEN - 32);
      default: sh = 7'd0;
    endcase
    shl  = rot << sh;
    sext = $signed(shl) >>> sh;
    ext  = rdu_q ? (shl >> sh) : sext;
  end

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    size_d   = size_q;
    rdu_d    = rdu_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    addr_d   = addr_q;
    dwdata_d = dwdata_q;
    valid_d  = 1'b0;
    wbo_d    = 1'b0;
    rdo_d    = '0;
    data_d   = '0;
    mis_d    = 1'b0;
    req_d    = 1'b0;
    dwe_d    = 1'b0;
    be_d     = '0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_mem_r || i_mem_w) begin
            off_d  = off_in;
            size_d = i_size;
            rdu_d  = i_mem_rdu;
            rd_d   = i_rd;
            wb_d   = i_writeback;
            if (trap_in) begin
              state_d = DONE;
              valid_d = 1'b1;
              mis_d   = 1'b1;
              rdo_d   = i_rd;
              data_d  = i_alu_result;
            end else begin
              state_d  = REQ;
              req_d    = 1'b1;
              dwe_d    = i_mem_w;
              be_d     = be_in;
              addr_d   = addr_in;
              dwdata_d = wdata_in;
            end
          end else begin
            valid_d = 1'b1;
            wbo_d   = i_writeback;
            rdo_d   = i_rd;
            data_d  = i_alu_result;
          end
        end
      end
      REQ: begin
        if (dmem.i_dmem_gnt) begin
          if (dwe_q) begin
            state_d = DONE;
            valid_d = 1'b1;
            rdo_d   = rd_q;
          end else begin
            state_d = RESP;
          end
        end else begin
          req_d = 1'b1;
          dwe_d = dwe_q;
          be_d  = be_q;
        end
      end
      RESP: begin
        if (dmem.i_dmem_rvalid) begin
          state_d = DONE;
          valid_d = 1'b1;
          wbo_d   = wb_q;
          rdo_d   = rd_q;
          data_d  = ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      off_q    <= '0;
      size_q   <= '0;
      rdu_q    <= 1'b0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      valid_q  <= 1'b0;
      wbo_q    <= 1'b0;
      rdo_q    <= '0;
      data_q   <= '0;
      mis_q    <= 1'b0;
      req_q    <= 1'b0;
      dwe_q    <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      dwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      size_q   <= size_d;
      rdu_q    <= rdu_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      valid_q  <= valid_d;
      wbo_q    <= wbo_d;
      rdo_q    <= rdo_d;
      data_q   <= data_d;
      mis_q    <= mis_d;
      req_q    <= req_d;
      dwe_q    <= dwe_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      dwdata_q <= dwdata_d;
    end
  end

  assign o_ready           = (state_q == IDLE);
  assign o_valid           = valid_q;
  assign o_writeback       = wbo_q;
  assign o_rd              = rdo_q;
  assign o_data            = data_q;
  assign o_misalign        = mis_q;
  assign dmem.o_dmem_req   = req_q;
  assign dmem.o_dmem_we    = dwe_q;
  assign dmem.o_dmem_be    = be_q;
  assign dmem.o_dmem_addr  = addr_q;
  assign dmem.o_dmem_wdata = dwdata_q;
endmodule
